// File: rtl/rf_wb_arb.sv
// rf_wb_arb -- register-file writeback arbiter with destination scoreboard.
//
// Two writeback sources compete for the single register-file write port:
// A (ALU) and B (load). Arbitration is combinational in the current cycle.
// When both request, the one that was not granted most recently wins.
// The winner's index and data are registered and presented to the register
// file one cycle later. A small scoreboard tracks destinations reserved by
// decode until their write reaches the register file.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-high reset
//   a_req      in   ALU writeback request (a_dest/a_data stable until acked)
//   a_dest     in   [2:0]  ALU destination index
//   a_data     in   [15:0] ALU result
//   a_ack      out  combinational grant to A this cycle
//   b_req      in   load writeback request
//   b_dest     in   [2:0]  load destination index
//   b_data     in   [15:0] load data
//   b_ack      out  combinational grant to B this cycle
//   mark_vld   in   decode reserves a destination this cycle
//   mark_dest  in   [2:0]  index being reserved
//   ld_rf      out  registered register-file write enable
//   dest       out  [2:0]  registered register-file write index
//   from_alu   out  [15:0] registered register-file write data
//   pend       out  [7:0]  scoreboard, bit i = write to register i outstanding
//   cont_cnt   out  [7:0]  saturating count of contested cycles
module rf_wb_arb #(
  parameter bit PRIO_A_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [2:0]  a_dest,
  input  logic [15:0] a_data,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [2:0]  b_dest,
  input  logic [15:0] b_data,
  output logic        b_ack,
  input  logic        mark_vld,
  input  logic [2:0]  mark_dest,
  output logic        ld_rf,
  output logic [2:0]  dest,
  output logic [15:0] from_alu,
  output logic [7:0]  pend,
  output logic [7:0]  cont_cnt
);

  // Which requester was granted most recently; the other one wins a tie.
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_t;

  // Pretending the opposite side went last makes the preferred side win
  // the first contested cycle.
  localparam last_t LAST_RST = PRIO_A_FIRST ? LAST_B : LAST_A;

  last_t      last_q;
  last_t      last_d;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;

  // Arbitration and pointer next-state.
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    a_ack  = 1'b0;
    b_ack  = 1'b0;
    last_d = last_q;
    // Acks are suppressed during reset even though the requests are live.
    if (!rst) begin
      if (a_req && (!b_req || last_q == LAST_B)) begin
        a_ack = 1'b1;
      end else if (b_req) begin
        b_ack = 1'b1;
      end
    end
    if (a_ack) begin
      last_d = LAST_A;
    end else if (b_ack) begin
      last_d = LAST_B;
    end
  end

  // Scoreboard update masks: decode sets, the register-file write clears.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (mark_vld) set_mask[mark_dest] = 1'b1;
    if (ld_rf)    clr_mask[dest]      = 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= LAST_RST;
      ld_rf    <= 1'b0;
      dest     <= '0;
      from_alu <= '0;
      pend     <= '0;
      cont_cnt <= '0;
    end else begin
      last_q <= last_d;
      ld_rf  <= a_ack | b_ack;
      // Index and data hold their last value in cycles with no grant.
      if (a_ack) begin
        dest     <= a_dest;
        from_alu <= a_data;
      end else if (b_ack) begin
        dest     <= b_dest;
        from_alu <= b_data;
      end
      // Clear first, then set, so a same-bit collision leaves the bit set.
      pend <= (pend & ~clr_mask) | set_mask;
      if (a_req && b_req && cont_cnt != 8'hFF) begin
        cont_cnt <= cont_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arb.sv
// tb_rf_wb_arb -- self-checking bench for rf_wb_arb (PRIO_A_FIRST = 1).
// Directed vector table, then hand-written sequences for saturation,
// mid-stream reset and a randomized ack-protocol run against a small model.
module tb_rf_wb_arb;

  logic        clk;
  logic        rst;
  logic        a_req;
  logic [2:0]  a_dest;
  logic [15:0] a_data;
  logic        a_ack;
  logic        b_req;
  logic [2:0]  b_dest;
  logic [15:0] b_data;
  logic        b_ack;
  logic        mark_vld;
  logic [2:0]  mark_dest;
  logic        ld_rf;
  logic [2:0]  dest;
  logic [15:0] from_alu;
  logic [7:0]  pend;
  logic [7:0]  cont_cnt;

  rf_wb_arb #(.PRIO_A_FIRST(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_dest   (a_dest),
    .a_data   (a_data),
    .a_ack    (a_ack),
    .b_req    (b_req),
    .b_dest   (b_dest),
    .b_data   (b_data),
    .b_ack    (b_ack),
    .mark_vld (mark_vld),
    .mark_dest(mark_dest),
    .ld_rf    (ld_rf),
    .dest     (dest),
    .from_alu (from_alu),
    .pend     (pend),
    .cont_cnt (cont_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        a_req;
    logic [2:0]  a_dest;
    logic [15:0] a_data;
    logic        b_req;
    logic [2:0]  b_dest;
    logic [15:0] b_data;
    logic        mark_vld;
    logic [2:0]  mark_dest;
    logic        e_a_ack;
    logic        e_b_ack;
    logic        e_ld_rf;
    logic [2:0]  e_dest;
    logic [15:0] e_data;
    logic [7:0]  e_pend;
    logic [7:0]  e_cnt;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs[NVEC];

  typedef struct packed {
    logic [2:0]  d;
    logic [15:0] v;
  } wr_t;
  wr_t wq[$];

  // Bench-side model state for the random phase.
  logic m_last_b;
  logic a_acked, b_acked;
  int   a_wait, b_wait;
  int   issued, acked;

  task automatic drive_idle();
    a_req = 1'b0; a_dest = '0; a_data = '0;
    b_req = 1'b0; b_dest = '0; b_data = '0;
    mark_vld = 1'b0; mark_dest = '0;
  endtask

  // One cycle of the random protocol run; gen=0 stops issuing new requests.
  task automatic rand_cycle(input bit gen);
    logic e_a, e_b;
    wr_t  w;
    @(negedge clk);
    if (!a_req || a_acked) begin
      a_req = gen && ($urandom_range(0, 2) != 0);
      a_dest = 3'($urandom); a_data = 16'($urandom); a_wait = 0;
      if (a_req) issued++;
    end
    if (!b_req || b_acked) begin
      b_req = gen && ($urandom_range(0, 2) != 0);
      b_dest = 3'($urandom); b_data = 16'($urandom); b_wait = 0;
      if (b_req) issued++;
    end
    #1;
    e_a = a_req && (!b_req || m_last_b);
    e_b = b_req && !e_a;
    check("rnd_ack", {a_ack, b_ack}, {e_a, e_b});
    check("rnd_not_both", 32'(a_ack & b_ack), 32'd0);
    a_acked = a_ack;
    b_acked = b_ack;
    if (a_ack) begin
      check("rnd_a_wait", 32'(a_wait <= 1), 32'd1);
      wq.push_back({a_dest, a_data}); acked++; m_last_b = 1'b0;
    end else if (a_req) a_wait++;
    if (b_ack) begin
      check("rnd_b_wait", 32'(b_wait <= 1), 32'd1);
      wq.push_back({b_dest, b_data}); acked++; m_last_b = 1'b1;
    end else if (b_req) b_wait++;
    @(posedge clk);
    #1;
    if (wq.size() > 0) begin
      w = wq.pop_front();
      check("rnd_ld_rf", 32'(ld_rf), 32'd1);
      check("rnd_dest", 32'(dest), 32'(w.d));
      check("rnd_data", 32'(from_alu), 32'(w.v));
    end else begin
      check("rnd_ld_rf_idle", 32'(ld_rf), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // {a_req,a_dest,a_data, b_req,b_dest,b_data, mark_vld,mark_dest,
    //  exp a_ack,b_ack, exp ld_rf,dest,from_alu,pend,cont_cnt after the edge}
    vecs[0]  = '{0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, 0,0,16'h0000,8'h00,8'd0};
    vecs[1]  = '{1,1,16'hAAAA, 1,2,16'hBBBB, 0,0, 1,0, 1,1,16'hAAAA,8'h00,8'd1};
    vecs[2]  = '{1,1,16'hAAAA, 1,2,16'hBBBB, 0,0, 0,1, 1,2,16'hBBBB,8'h00,8'd2};
    vecs[3]  = '{1,1,16'hAAAA, 1,2,16'hBBBB, 0,0, 1,0, 1,1,16'hAAAA,8'h00,8'd3};
    vecs[4]  = '{1,1,16'hAAAA, 1,2,16'hBBBB, 0,0, 0,1, 1,2,16'hBBBB,8'h00,8'd4};
    vecs[5]  = '{1,3,16'h1234, 0,0,16'h0000, 0,0, 1,0, 1,3,16'h1234,8'h00,8'd4};
    vecs[6]  = '{0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, 0,3,16'h1234,8'h00,8'd4};
    vecs[7]  = '{0,0,16'h0000, 0,0,16'h0000, 1,5, 0,0, 0,3,16'h1234,8'h20,8'd4};
    vecs[8]  = '{0,0,16'h0000, 1,5,16'h0055, 0,0, 0,1, 1,5,16'h0055,8'h20,8'd4};
    vecs[9]  = '{0,0,16'h0000, 0,0,16'h0000, 1,5, 0,0, 0,5,16'h0055,8'h20,8'd4};
    vecs[10] = '{0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, 0,5,16'h0055,8'h20,8'd4};
    vecs[11] = '{0,0,16'h0000, 1,5,16'h5A5A, 1,6, 0,1, 1,5,16'h5A5A,8'h60,8'd4};
    vecs[12] = '{1,2,16'h0202, 0,0,16'h0000, 1,1, 1,0, 1,2,16'h0202,8'h42,8'd4};
    vecs[13] = '{0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, 0,2,16'h0202,8'h42,8'd4};
    vecs[14] = '{1,6,16'h6666, 1,6,16'h7777, 0,0, 0,1, 1,6,16'h7777,8'h42,8'd5};
    vecs[15] = '{1,6,16'h6666, 0,0,16'h0000, 0,0, 1,0, 1,6,16'h6666,8'h02,8'd5};
    vecs[16] = '{0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, 0,6,16'h6666,8'h02,8'd5};
    vecs[17] = '{1,7,16'h0007, 0,0,16'h0000, 0,0, 1,0, 1,7,16'h0007,8'h02,8'd5};
    vecs[18] = '{1,0,16'h0100, 0,0,16'h0000, 0,0, 1,0, 1,0,16'h0100,8'h02,8'd5};
    vecs[19] = '{0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, 0,0,16'h0100,8'h02,8'd5};

    // Reset state, with both requests asserted to show acks stay low.
    rst = 1'b1;
    drive_idle();
    #3;
    a_req = 1'b1; b_req = 1'b1;
    #1;
    check("rst_acks", {a_ack, b_ack}, 2'b00);
    check("rst_ld_rf", 32'(ld_rf), 32'd0);
    check("rst_dest", 32'(dest), 32'd0);
    check("rst_data", 32'(from_alu), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    check("rst_cnt", 32'(cont_cnt), 32'd0);
    @(negedge clk);
    drive_idle();
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      a_req = vecs[i].a_req; a_dest = vecs[i].a_dest; a_data = vecs[i].a_data;
      b_req = vecs[i].b_req; b_dest = vecs[i].b_dest; b_data = vecs[i].b_data;
      mark_vld = vecs[i].mark_vld; mark_dest = vecs[i].mark_dest;
      #1;
      check($sformatf("v%0d_acks", i), {a_ack, b_ack}, {vecs[i].e_a_ack, vecs[i].e_b_ack});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ld_rf", i), 32'(ld_rf), 32'(vecs[i].e_ld_rf));
      check($sformatf("v%0d_dest", i), 32'(dest), 32'(vecs[i].e_dest));
      check($sformatf("v%0d_data", i), 32'(from_alu), 32'(vecs[i].e_data));
      check($sformatf("v%0d_pend", i), 32'(pend), 32'(vecs[i].e_pend));
      check($sformatf("v%0d_cnt", i), 32'(cont_cnt), 32'(vecs[i].e_cnt));
    end

    // Saturation: both requesting for 300 cycles; A was granted last.
    m_last_b = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a_req = 1'b1; a_dest = 3'd3; a_data = 16'hA000 + 16'(i);
      b_req = 1'b1; b_dest = 3'd4; b_data = 16'hB000 + 16'(i);
      mark_vld = 1'b0;
      #1;
      check("sat_acks", {a_ack, b_ack}, {m_last_b, ~m_last_b});
      m_last_b = ~m_last_b;
      @(posedge clk);
      #1;
      if (i == 248) check("sat_cnt_254", 32'(cont_cnt), 32'd254);
      if (i == 249) check("sat_cnt_255", 32'(cont_cnt), 32'd255);
      if (i == 299) check("sat_cnt_hold", 32'(cont_cnt), 32'd255);
    end

    // Reset asserted during the ld_rf cycle of a granted write.
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    a_req = 1'b1; a_dest = 3'd4; a_data = 16'h4444;
    mark_vld = 1'b1; mark_dest = 3'd3;
    #1;
    check("mr_a_ack", {a_ack, b_ack}, 2'b10);
    @(posedge clk);
    #1;
    check("mr_ld_rf_pre", 32'(ld_rf), 32'd1);
    check("mr_pend_pre", 32'(pend), 32'h0A);
    check("mr_cnt_pre", 32'(cont_cnt), 32'd255);
    #2;
    drive_idle();
    rst = 1'b1;
    #1;
    check("mr_ld_rf", 32'(ld_rf), 32'd0);
    check("mr_pend", 32'(pend), 32'd0);
    check("mr_cnt", 32'(cont_cnt), 32'd0);
    check("mr_dest", 32'(dest), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("mr_idle_ld_rf", 32'(ld_rf), 32'd0);
    end
    // Pointer is back at its reset value: A wins the first contest.
    @(negedge clk);
    a_req = 1'b1; a_dest = 3'd1; a_data = 16'hC001;
    b_req = 1'b1; b_dest = 3'd2; b_data = 16'hC002;
    #1;
    check("mr_first_contest", {a_ack, b_ack}, 2'b10);
    @(posedge clk);
    #1;
    check("mr_after_dest", 32'(dest), 32'd1);
    check("mr_after_data", 32'(from_alu), 32'hC001);
    check("mr_after_cnt", 32'(cont_cnt), 32'd1);
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;

    // Random ack-protocol run; A was granted last.
    m_last_b = 1'b0;
    a_acked = 1'b0; b_acked = 1'b0;
    a_wait = 0; b_wait = 0;
    issued = 0; acked = 0;
    for (int i = 0; i < 200; i++) rand_cycle(1'b1);
    for (int i = 0; i < 4; i++) rand_cycle(1'b0);
    check("rnd_issued_eq_acked", 32'(issued), 32'(acked));
    check("rnd_queue_empty", 32'(wq.size()), 32'd0);
    check("rnd_reqs_drained", {a_req, b_req}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
